// File: rtl/pci_pkg.sv
// pci_pkg
//   Shared definitions for the PCI bus monitor: bus command codes,
//   monitor FSM state encoding, protocol error codes and the
//   "no master granted" marker.
package pci_pkg;

    // Bus command codes carried on C_BE during the address phase.
    localparam logic [3:0] CMD_IO_READ   = 4'b0010;
    localparam logic [3:0] CMD_IO_WRITE  = 4'b0011;
    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    // Number of arbiter grant lines observed.
    localparam int unsigned NUM_GNT = 5;

    // Master index reported when no grant line is low.
    localparam logic [2:0] NO_MASTER = 3'd7;

    // Protocol error codes.
    localparam logic [1:0] ERR_NONE           = 2'd0;
    localparam logic [1:0] ERR_IRDY_IDLE      = 2'd1;
    localparam logic [1:0] ERR_FRAME_RELEASE  = 2'd2;
    localparam logic [1:0] ERR_TRDY_NO_DEVSEL = 2'd3;

    // Monitor FSM states.
    typedef enum logic [2:0] {
        ST_RESYNC,
        ST_IDLE,
        ST_WAIT_DEVSEL,
        ST_DATA,
        ST_TURNAROUND
    } mon_state_t;

endpackage

// File: rtl/pci_gnt_encoder.sv
// pci_gnt_encoder
//   Combinational priority encoder for the active-low arbiter grants.
//   The lowest-indexed low grant line wins.
// Ports:
//   i_gnt_n  in  5  arbiter grants, active-low
//   o_index  out 3  index of the winning grant, NO_MASTER if none
//   o_valid  out 1  high when at least one grant is low
module pci_gnt_encoder
    import pci_pkg::*;
(
    input  logic [NUM_GNT-1:0] i_gnt_n,
    output logic [2:0]         o_index,
    output logic               o_valid
);

    always_comb begin
        o_index = NO_MASTER;
        o_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_GNT; i++) begin
            if (!i_gnt_n[i] && !o_valid) begin
                o_index = 3'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pci_bus_monitor.sv
// pci_bus_monitor
//   Passive PCI bus observer. Reconstructs each bus transaction from the
//   sampled handshake signals and emits one record per completed or
//   master-aborted transaction; flags basic handshake violations.
// Parameters:
//   DEVSEL_TIMEOUT  edges after the address phase without DEVSEL before
//                   a master abort is declared (>= 1)
// Ports:
//   clk, reset             bus clock, synchronous active-high reset
//   FRAME/IRDY/TRDY/DEVSEL active-low bus handshakes (observe only)
//   AD, C_BE, GNT          address/data, command/byte enables, grants
//   txn_*                  transaction record, valid during txn_valid
//   err_valid, err_code    protocol violation pulse and code
module pci_bus_monitor
    import pci_pkg::*;
#(
    parameter int unsigned DEVSEL_TIMEOUT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FRAME,
    input  logic        IRDY,
    input  logic        TRDY,
    input  logic        DEVSEL,
    input  logic [31:0] AD,
    input  logic [3:0]  C_BE,
    input  logic [4:0]  GNT,
    output logic        txn_valid,
    output logic [31:0] txn_addr,
    output logic [3:0]  txn_cmd,
    output logic [2:0]  txn_master,
    output logic [7:0]  txn_count,
    output logic [31:0] txn_first_data,
    output logic [31:0] txn_last_data,
    output logic        txn_abort,
    output logic        err_valid,
    output logic [1:0]  err_code
);

    localparam int unsigned TW = $clog2(DEVSEL_TIMEOUT + 1);

    mon_state_t r_state, w_next_state;

    // Working record for the transaction in flight.
    logic [31:0]   r_addr, r_first, r_last;
    logic [3:0]    r_cmd;
    logic [2:0]    r_master;
    logic [7:0]    r_count;
    logic [TW-1:0] r_timer;

    // Published record / error outputs.
    logic        r_rec_pend, r_txn_valid, r_txn_abort;
    logic [31:0] r_txn_addr, r_txn_first, r_txn_last;
    logic [3:0]  r_txn_cmd;
    logic [2:0]  r_txn_master;
    logic [7:0]  r_txn_count;
    logic        r_err_pend, r_err_valid;
    logic [1:0]  r_err_code;

    logic [2:0]    w_gnt_idx;
    logic          w_gnt_valid;
    logic [TW-1:0] w_timer_next;
    logic          w_timeout, w_data_eval, w_xfer, w_final;
    logic          w_latch, w_timer_inc, w_emit, w_abort;
    logic [1:0]    w_err_code;
    logic [7:0]    w_count_inc, w_rec_count;
    logic [31:0]   w_rec_first, w_rec_last;

    pci_gnt_encoder u_gnt_enc (
        .i_gnt_n (GNT),
        .o_index (w_gnt_idx),
        .o_valid (w_gnt_valid)
    );

    // Shared decode: the DEVSEL edge in WAIT_DEVSEL is evaluated as a data
    // phase on the same edge, so both states use the same transfer terms.
    always_comb begin
        w_timer_next = r_timer + TW'(1);
        w_timeout    = (r_state == ST_WAIT_DEVSEL) && DEVSEL &&
                       (w_timer_next == TW'(DEVSEL_TIMEOUT));
        w_data_eval  = (r_state == ST_DATA) ||
                       ((r_state == ST_WAIT_DEVSEL) && !DEVSEL);
        w_xfer       = w_data_eval && !IRDY && !TRDY;
        w_final      = w_xfer && FRAME;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_RESYNC;
        else       r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_RESYNC:     if (FRAME && IRDY) w_next_state = ST_IDLE;
            ST_IDLE:       if (!FRAME)        w_next_state = ST_WAIT_DEVSEL;
            ST_WAIT_DEVSEL,
            ST_DATA: begin
                if (w_data_eval) begin
                    if (w_final)             w_next_state = ST_TURNAROUND;
                    else if (FRAME && IRDY)  w_next_state = ST_IDLE;
                    else                     w_next_state = ST_DATA;
                end else if (w_timeout) begin
                    w_next_state = ST_TURNAROUND;
                end
            end
            ST_TURNAROUND: if (FRAME && IRDY) w_next_state = ST_IDLE;
            default:       w_next_state = ST_RESYNC;
        endcase
    end

    // Output decode: datapath strobes, record emission, error selection.
    // Error checks are ordered so the lowest code wins.
    always_comb begin
        w_latch     = (r_state == ST_IDLE) && !FRAME;
        w_timer_inc = (r_state == ST_WAIT_DEVSEL) && DEVSEL;
        w_abort     = w_timeout;
        w_emit      = 1'b0;
        w_err_code  = ERR_NONE;
        if (r_state == ST_IDLE && FRAME && !IRDY) begin
            w_err_code = ERR_IRDY_IDLE;
        end else if (w_data_eval) begin
            if (FRAME && IRDY)        w_err_code = ERR_FRAME_RELEASE;
            else if (!TRDY && DEVSEL) w_err_code = ERR_TRDY_NO_DEVSEL;
        end
        if (w_timeout || w_final || (w_data_eval && FRAME && IRDY))
            w_emit = 1'b1;

        w_count_inc = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
        w_rec_count = w_xfer ? w_count_inc : r_count;
        w_rec_last  = w_xfer ? AD : r_last;
        w_rec_first = (w_xfer && r_count == 8'd0) ? AD : r_first;
    end

    // Datapath. Record fields load on the event edge; the valid pulse
    // follows one edge later so it lands after the final-transfer edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_cmd        <= '0;
            r_master     <= '0;
            r_count      <= '0;
            r_first      <= '0;
            r_last       <= '0;
            r_timer      <= '0;
            r_rec_pend   <= 1'b0;
            r_txn_valid  <= 1'b0;
            r_txn_addr   <= '0;
            r_txn_cmd    <= '0;
            r_txn_master <= '0;
            r_txn_count  <= '0;
            r_txn_first  <= '0;
            r_txn_last   <= '0;
            r_txn_abort  <= 1'b0;
            r_err_pend   <= 1'b0;
            r_err_valid  <= 1'b0;
            r_err_code   <= '0;
        end else begin
            r_rec_pend  <= w_emit;
            r_txn_valid <= r_rec_pend;
            r_err_pend  <= (w_err_code != ERR_NONE);
            r_err_valid <= r_err_pend;
            if (w_err_code != ERR_NONE) r_err_code <= w_err_code;

            if (w_emit) begin
                r_txn_addr   <= r_addr;
                r_txn_cmd    <= r_cmd;
                r_txn_master <= r_master;
                r_txn_count  <= w_rec_count;
                r_txn_first  <= w_rec_first;
                r_txn_last   <= w_rec_last;
                r_txn_abort  <= w_abort;
            end

            if (w_latch) begin
                r_addr   <= AD;
                r_cmd    <= C_BE;
                r_master <= w_gnt_valid ? w_gnt_idx : NO_MASTER;
                r_count  <= '0;
                r_first  <= '0;
                r_last   <= '0;
                r_timer  <= '0;
            end else begin
                if (w_timer_inc) r_timer <= w_timer_next;
                if (w_xfer) begin
                    r_count <= w_rec_count;
                    r_first <= w_rec_first;
                    r_last  <= w_rec_last;
                end
            end
        end
    end

    assign txn_valid      = r_txn_valid;
    assign txn_addr       = r_txn_addr;
    assign txn_cmd        = r_txn_cmd;
    assign txn_master     = r_txn_master;
    assign txn_count      = r_txn_count;
    assign txn_first_data = r_txn_first;
    assign txn_last_data  = r_txn_last;
    assign txn_abort      = r_txn_abort;
    assign err_valid      = r_err_valid;
    assign err_code       = r_err_code;

endmodule

// File: doc/pci_bus_monitor.md
# pci_bus_monitor

Passive observer on the shared PCI bus. It samples FRAME, IRDY, TRDY, DEVSEL, AD, C_BE and GNT every clock, reconstructs each bus transaction and emits one record per completed or master-aborted transaction. It also flags basic handshake protocol violations. It sits downstream of the Device initiators/targets and the arbitration block, and drives nothing on the bus.

## Interface
- `DEVSEL_TIMEOUT`, default 5: edges after the address phase without DEVSEL low before a master abort is declared (≥1).
- `clk` in 1: bus clock; all sampling on posedge.
- `reset` in 1: synchronous, active-high.
- `FRAME` in 1: active-low bus signal, observe only.
- `IRDY` in 1: active-low, observe only.
- `TRDY` in 1: active-low, observe only.
- `DEVSEL` in 1: active-low, observe only.
- `AD` in 32: address/data bus.
- `C_BE` in 4: command (address phase) or byte enables (data phase).
- `GNT` in 5: arbiter grants, active-low, one-hot-low.
- `txn_valid` out 1: one-cycle pulse; record fields valid while high.
- `txn_addr` out 32: AD sampled at the address phase.
- `txn_cmd` out 4: C_BE sampled at the address phase.
- `txn_master` out 3: lowest index with GNT low at the address phase; 3'd7 if none.
- `txn_count` out 8: completed data phases, saturating at 255.
- `txn_first_data` out 32: AD at the first completed data phase; 0 if none.
- `txn_last_data` out 32: AD at the last completed data phase; 0 if none.
- `txn_abort` out 1: master abort (DEVSEL timeout).
- `err_valid` out 1: one-cycle pulse on a protocol violation.
- `err_code` out 2: 1 = IRDY low while idle; 2 = FRAME released with IRDY high; 3 = TRDY low with DEVSEL high.

## Operation
- States: RESYNC, IDLE, WAIT_DEVSEL, DATA, TURNAROUND.
- Reset state is RESYNC. All outputs and record registers are 0; `err_code` is 0.
- RESYNC: go to IDLE on the first edge where FRAME and IRDY are both high. No errors or records are produced in this state.
- IDLE:
  - FRAME low: latch AD→addr and C_BE→cmd, encode GNT→master, clear count/data/timer, go to WAIT_DEVSEL.
  - IRDY low with FRAME high: error 1, stay in IDLE.
- WAIT_DEVSEL:
  - DEVSEL low: enter DATA and evaluate the data-phase rules on the same edge.
  - Otherwise increment the timer. When the timer reaches `DEVSEL_TIMEOUT`, emit a record with abort=1 and count=0, then go to TURNAROUND.
- DATA, per edge:
  - Transfer when IRDY and TRDY are both low:
    - Count increments, saturating at 255.
    - last_data ← AD.
    - first_data ← AD if count was 0.
    - If FRAME is high on that transfer edge, it is the final phase: emit the record and go to TURNAROUND.
  - FRAME high with IRDY high: error 2, emit the record as is, go to IDLE.
  - TRDY low with DEVSEL high: error 3, stay in DATA.
- TURNAROUND: go to IDLE when FRAME and IRDY are both high. A FRAME-low edge here starts no transaction.
- Simultaneous errors: the lowest code wins. Only one `err_valid` per edge.
- `txn_master`: GNT bits are priority-encoded, lowest index wins.

## Timing
- Record latency: `txn_valid` rises on the edge after the final-transfer or timeout edge, and lasts exactly one cycle.
- `err_valid` rises on the edge after the offending sample, and lasts exactly one cycle.
- The record fields hold their values until the next record.
- Back-to-back transactions with one idle turnaround cycle are supported. Record pulses are never merged.
- Reset mid-transaction: the partial record is discarded and no `txn_valid` is produced. Monitoring resumes only after RESYNC.
- Address-to-abort latency: `DEVSEL_TIMEOUT` + 1 edges.

## Structure
- Package `pci_pkg` holds:
  - Command codes: IO_READ 4'b0010, IO_WRITE 4'b0011, MEM_READ 4'b0110, MEM_WRITE 4'b0111.
  - The monitor state encoding.
  - Error-code constants.
  - The `NO_MASTER` = 3'd7 constant.
- One sub-module, `pci_gnt_encoder`: combinational GNT[4:0] active-low → 3-bit index plus a valid bit.

## Test plan
- **Single write:** GNT=5'b01111, FRAME low, AD=32'h10, C_BE=4'b0111. Next edge: DEVSEL/IRDY/TRDY low, FRAME high, AD=32'hDEADBEEF. Required: one `txn_valid` with addr 32'h10, cmd 7, master 4, count 1, first=last=DEADBEEF, abort 0.
- **Burst of 4 with one TRDY wait state:** data words 1, 2, 3, 4. Required: count 4, first 1, last 4; `txn_valid` lands 1 cycle after the 4th transfer.
- **No DEVSEL, `DEVSEL_TIMEOUT`=5:** required `txn_valid` exactly 6 edges after the address phase, with abort=1, count 0, data 0.
- **IRDY low for one cycle while FRAME high and idle:** required `err_valid` with `err_code`=1 and no `txn_valid`.
- **Reset asserted during the 2nd data phase of a burst, released with FRAME still low:** no record for that burst. The next clean single read (cmd 6) is reported correctly.
- **300-phase burst:** required `txn_count`=255, with last_data equal to the 300th word.
